prbs_edge_shaper: RTL and testbench

Downstream stage of `prbs_core_lfsr` in the PRBS waveform path. It takes the serial PRBS bit and its bit-rate strobe and converts each bit into an unsigned DAC code. The code sits at a programmable high or low level, and transitions between levels use a programmable slew step. The output drives the DAC data path in the `dac_clk` domain.

---
 rtl/prbs_edge_shaper.sv | 94 +++++++++
 tb/tb_prbs_edge_shaper.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_edge_shaper.sv
// rtl/prbs_edge_shaper.sv - PRBS bit to slew-limited DAC code shaper
module prbs_edge_shaper #(
    parameter int DAC_W = 14
) (
    input  logic             dac_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             lfsr_clk_enable,
    input  logic             prbs_bit_out,
    input  logic [DAC_W-1:0] level_hi_reg,
    input  logic [DAC_W-1:0] level_lo_reg,
    input  logic [DAC_W-1:0] slew_step_reg,
    input  logic             polarity_inv,
    output logic [DAC_W-1:0] dac_data,
    output logic             dac_valid,
    output logic             edge_busy
);

    localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_stb_d;
    logic [DAC_W-1:0] r_target;
    logic [DAC_W-1:0] w_next_target;
    logic [DAC_W-1:0] r_data;
    logic [DAC_W-1:0] w_next_data;
    logic             r_busy;
    logic             w_next_busy;

    logic             w_capture;
    logic [DAC_W-1:0] w_cap_target;
    logic [DAC_W-1:0] w_step_target;
    logic [DAC_W:0]   w_diff;
    logic             w_neg;
    logic [DAC_W:0]   w_abs;
    logic             w_jump;
    logic [DAC_W-1:0] w_stepped;

    assign w_capture     = r_stb_d & enable;
    assign w_cap_target  = (prbs_bit_out ^ polarity_inv) ? level_hi_reg : level_lo_reg;
    // The step on a capture edge is computed against the freshly selected level.
    assign w_step_target = w_capture ? w_cap_target : r_target;

    assign w_diff    = {1'b0, w_step_target} - {1'b0, r_data};
    assign w_neg     = w_diff[DAC_W];
    assign w_abs     = w_neg ? ({1'b0, r_data} - {1'b0, w_step_target}) : w_diff;
    assign w_jump    = (slew_step_reg == '0) || (w_abs <= {1'b0, slew_step_reg});
    assign w_stepped = w_jump ? w_step_target
                     : (w_neg ? (r_data - slew_step_reg) : (r_data + slew_step_reg));

    always_comb begin
        w_next_state  = r_state;
        w_next_target = r_target;
        w_next_data   = r_data;
        w_next_busy   = 1'b0;
        if (!enable) begin
            w_next_state = S_IDLE;
            w_next_data  = MID;
        end else if (w_capture || (r_state == S_RAMP)) begin
            w_next_target = w_step_target;
            w_next_data   = w_stepped;
            w_next_busy   = (w_stepped != w_step_target);
            w_next_state  = w_next_busy ? S_RAMP : S_HOLD;
        end
    end

    always_ff @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_stb_d  <= 1'b0;
            r_target <= MID;
            r_data   <= MID;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_stb_d  <= lfsr_clk_enable;
            r_target <= w_next_target;
            r_data   <= w_next_data;
            r_busy   <= w_next_busy;
        end
    end

    assign dac_data  = r_data;
    assign dac_valid = (r_state == S_RAMP) || (r_state == S_HOLD);
    assign edge_busy = r_busy;

endmodule

// File: tb/tb_prbs_edge_shaper.sv
// tb/tb_prbs_edge_shaper.sv - table vectors plus randomized model check for prbs_edge_shaper
module tb_prbs_edge_shaper;

    localparam int DAC_W = 14;
    localparam int MID   = 8192;

    logic             dac_clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             lfsr_clk_enable;
    logic             prbs_bit_out;
    logic [DAC_W-1:0] level_hi_reg;
    logic [DAC_W-1:0] level_lo_reg;
    logic [DAC_W-1:0] slew_step_reg;
    logic             polarity_inv;
    logic [DAC_W-1:0] dac_data;
    logic             dac_valid;
    logic             edge_busy;

    prbs_edge_shaper #(.DAC_W(DAC_W)) dut (
        .dac_clk        (dac_clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .lfsr_clk_enable(lfsr_clk_enable),
        .prbs_bit_out   (prbs_bit_out),
        .level_hi_reg   (level_hi_reg),
        .level_lo_reg   (level_lo_reg),
        .slew_step_reg  (slew_step_reg),
        .polarity_inv   (polarity_inv),
        .dac_data       (dac_data),
        .dac_valid      (dac_valid),
        .edge_busy      (edge_busy)
    );

    always #5 dac_clk = ~dac_clk;

    typedef struct {
        logic en;
        logic stb;
        logic bt;
        logic pol;
        int   hi;
        int   lo;
        int   step;
        int   e_data;
        logic e_valid;
        logic e_busy;
    } vec_t;

    vec_t tv[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic c_en, c_pol;
    int   c_hi, c_lo, c_step;

    int   m_data, m_target;
    logic m_active, m_stb;

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx, input int d, input int v, input int b);
        check({tag, ".data"},  idx, int'(dac_data),  d);
        check({tag, ".valid"}, idx, int'(dac_valid), v);
        check({tag, ".busy"},  idx, int'(edge_busy), b);
    endtask

    task automatic add(input logic stb, input logic bt, input int d, input logic v, input logic b);
        vec_t x;
        x.en = c_en; x.stb = stb; x.bt = bt; x.pol = c_pol;
        x.hi = c_hi; x.lo = c_lo; x.step = c_step;
        x.e_data = d; x.e_valid = v; x.e_busy = b;
        tv.push_back(x);
    endtask

    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    function automatic int move_toward(input int cur, input int tgt, input int step);
        int d;
        d = tgt - cur;
        if (step == 0 || (d < 0 ? -d : d) <= step) return tgt;
        return (d > 0) ? cur + step : cur - step;
    endfunction

    task automatic model_reset();
        m_data = MID; m_target = MID; m_active = 1'b0; m_stb = 1'b0;
    endtask

    // Advance the reference by one edge using the inputs currently on the pins.
    task automatic model_edge();
        if (!enable) begin
            m_active = 1'b0;
            m_data   = MID;
        end else begin
            if (m_stb) begin
                m_target = (prbs_bit_out ^ polarity_inv) ? int'(level_hi_reg) : int'(level_lo_reg);
                m_active = 1'b1;
            end
            if (m_active) m_data = move_toward(m_data, m_target, int'(slew_step_reg));
        end
        m_stb = lfsr_clk_enable;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; lfsr_clk_enable = 1'b0; prbs_bit_out = 1'b0;
        level_hi_reg = '0; level_lo_reg = '0; slew_step_reg = '0; polarity_inv = 1'b0;
        #12;
        check_outs("reset", 0, MID, 0, 0);
        @(negedge dac_clk);
        reset_n = 1'b1;
        #1;

        c_en = 1'b1; c_hi = 12000; c_lo = 4000; c_step = 0; c_pol = 1'b0;
        add(0, 0, 8192, 0, 0);
        add(0, 0, 8192, 0, 0);
        add(1, 0, 8192, 0, 0);
        add(0, 1, 12000, 1, 0);
        add(1, 0, 12000, 1, 0);
        add(0, 0, 4000, 1, 0);
        c_step = 1000;
        add(1, 0, 4000, 1, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 4000 + 1000 * i, 1, (i < 8));
        c_step = 3000;
        add(1, 0, 12000, 1, 0);
        add(0, 0, 9000, 1, 1);
        add(0, 0, 6000, 1, 1);
        add(0, 0, 4000, 1, 0);
        add(1, 0, 4000, 1, 0);
        add(0, 1, 7000, 1, 1);
        add(0, 1, 10000, 1, 1);
        add(0, 1, 12000, 1, 0);
        add(1, 0, 12000, 1, 0);
        add(0, 0, 9000, 1, 1);
        add(0, 0, 6000, 1, 1);
        add(0, 0, 4000, 1, 0);
        c_step = 1000;
        add(1, 0, 4000, 1, 0);
        add(0, 1, 5000, 1, 1);
        add(0, 1, 6000, 1, 1);
        add(1, 1, 7000, 1, 1);
        add(0, 0, 6000, 1, 1);
        add(0, 0, 5000, 1, 1);
        add(0, 0, 4000, 1, 0);
        add(0, 0, 4000, 1, 0);
        c_step = 0; c_pol = 1'b1;
        add(1, 0, 4000, 1, 0);
        c_lo = 2000;
        add(0, 1, 2000, 1, 0);
        c_lo = 3000;
        add(0, 1, 2000, 1, 0);
        add(1, 1, 2000, 1, 0);
        add(0, 1, 3000, 1, 0);
        add(1, 0, 3000, 1, 0);
        add(0, 0, 12000, 1, 0);
        c_step = 1000;
        add(1, 0, 12000, 1, 0);
        add(0, 1, 11000, 1, 1);
        c_en = 1'b0;
        add(0, 0, 8192, 0, 0);
        c_en = 1'b1;
        add(1, 0, 8192, 0, 0);
        c_en = 1'b0;
        add(0, 1, 8192, 0, 0);
        c_en = 1'b1;
        add(0, 0, 8192, 0, 0);
        c_pol = 1'b0;
        add(1, 0, 8192, 0, 0);
        add(0, 1, 9192, 1, 1);
        add(0, 1, 10192, 1, 1);
        add(1, 1, 11192, 1, 1);
        add(1, 0, 10192, 1, 1);
        add(1, 1, 11192, 1, 1);
        add(0, 1, 12000, 1, 0);
        c_step = 0; c_hi = 5000; c_lo = 5000;
        add(1, 0, 12000, 1, 0);
        add(0, 0, 5000, 1, 0);
        add(1, 0, 5000, 1, 0);
        add(0, 1, 5000, 1, 0);

        foreach (tv[i]) begin
            enable = tv[i].en; lfsr_clk_enable = tv[i].stb; prbs_bit_out = tv[i].bt;
            polarity_inv = tv[i].pol; level_hi_reg = DAC_W'(tv[i].hi);
            level_lo_reg = DAC_W'(tv[i].lo); slew_step_reg = DAC_W'(tv[i].step);
            tick();
            check_outs("vec", i, tv[i].e_data, tv[i].e_valid, tv[i].e_busy);
        end

        // Asynchronous reset between edges, mid-ramp.
        level_hi_reg = 14'd16000; level_lo_reg = 14'd100; slew_step_reg = 14'd50;
        lfsr_clk_enable = 1'b1; tick();
        lfsr_clk_enable = 1'b0; prbs_bit_out = 1'b0; tick();
        tick();
        #2 reset_n = 1'b0;
        #1 check_outs("async_rst", 0, MID, 0, 0);
        @(negedge dac_clk);
        reset_n = 1'b1;
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            int sel;
            enable          = ($urandom_range(0, 99) < 96);
            lfsr_clk_enable = ($urandom_range(0, 99) < 25);
            prbs_bit_out    = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 5) polarity_inv = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 10) begin
                level_hi_reg = DAC_W'($urandom);
                level_lo_reg = ($urandom_range(0, 9) == 0) ? level_hi_reg : DAC_W'($urandom);
            end
            if ($urandom_range(0, 99) < 3) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: slew_step_reg = '0;
                    1: slew_step_reg = DAC_W'($urandom_range(1, 300));
                    2: slew_step_reg = DAC_W'($urandom_range(1000, 5000));
                    default: slew_step_reg = DAC_W'($urandom);
                endcase
            end
            model_edge();
            tick();
            check_outs("rand", i, m_data, int'(m_active), int'(m_active && (m_data != m_target)));
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                #1 check_outs("rand_rst", i, MID, 0, 0);
                @(negedge dac_clk);
                reset_n = 1'b1;
                model_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
